// File: rtl/gbe64_tx_overrun_monitor.sv
// gbe64_tx_overrun_monitor
// Frame gate and overrun monitor placed in front of the 64-bit 10GbE transmit core.
// A frame whose first word arrives while the core is almost full (or overflowing) is dropped
// whole. Frames that have already started always complete. Overflow rising edges and dropped
// frames are counted in saturating counters, and both counters are packed into a status word
// that software reads.
//
// Ports:
//   user_clk      sole clock (10GbE fabric domain)
//   user_rst_n    synchronous active-low reset
//   tx_data_in    frame data from the packetiser
//   tx_valid_in   data word valid
//   tx_eof_in     last word of frame (qualified by tx_valid_in)
//   tx_afull      almost-full flag from the core
//   tx_overflow   overflow level from the core
//   clr           software clear of the counters and the sticky bit (level)
//   tx_data_out   registered data to the core
//   tx_valid_out  registered valid to the core
//   tx_eof_out    registered end-of-frame to the core
//   overrun_word  {sticky overflow, afull_q, drop count, event count}
//
// EVT_W + DROP_W must equal 30 so that the two counters fill bits [29:0] of the status word.
module gbe64_tx_overrun_monitor #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned EVT_W  = 16,
  parameter int unsigned DROP_W = 14
) (
  input  logic              user_clk,
  input  logic              user_rst_n,
  input  logic [DATA_W-1:0] tx_data_in,
  input  logic              tx_valid_in,
  input  logic              tx_eof_in,
  input  logic              tx_afull,
  input  logic              tx_overflow,
  input  logic              clr,
  output logic [DATA_W-1:0] tx_data_out,
  output logic              tx_valid_out,
  output logic              tx_eof_out,
  output logic [31:0]       overrun_word
);

  typedef enum logic [1:0] {StIdle, StPass, StDrop} state_e;

  state_e state_q, state_d;

  logic [DATA_W-1:0] data_q;
  logic              valid_q, eof_q;
  logic              ovf_prev_q, sticky_q, afull_q;
  logic [EVT_W-1:0]  evt_cnt_q;
  logic [DROP_W-1:0] drop_cnt_q;

  logic fwd, drop_start, ovf_edge, blocked;

  assign blocked  = tx_afull | tx_overflow;
  assign ovf_edge = tx_overflow & ~ovf_prev_q;

  // Gating and next-state decision. Only a frame start samples the core flags.
  always_comb begin
    state_d    = state_q;
    fwd        = 1'b0;
    drop_start = 1'b0;
    if (tx_valid_in) begin
      unique case (state_q)
        StIdle: begin
          if (blocked) begin
            drop_start = 1'b1;
            state_d    = tx_eof_in ? StIdle : StDrop;
          end else begin
            fwd     = 1'b1;
            state_d = tx_eof_in ? StIdle : StPass;
          end
        end
        StPass: begin
          fwd = 1'b1;
          if (tx_eof_in) state_d = StIdle;
        end
        StDrop: begin
          if (tx_eof_in) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      state_q <= StIdle;
      data_q  <= '0;
      valid_q <= 1'b0;
      eof_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= tx_data_in;
      valid_q <= fwd;
      eof_q   <= fwd & tx_eof_in;
    end
  end

  // Status registers. Clear wins over a same-cycle event or drop; counters stick at all-ones.
  always_ff @(posedge user_clk) begin
    if (!user_rst_n) begin
      ovf_prev_q <= 1'b0;
      afull_q    <= 1'b0;
      sticky_q   <= 1'b0;
      evt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      ovf_prev_q <= tx_overflow;
      afull_q    <= tx_afull;
      if (clr) begin
        sticky_q   <= 1'b0;
        evt_cnt_q  <= '0;
        drop_cnt_q <= '0;
      end else begin
        if (ovf_edge) begin
          sticky_q <= 1'b1;
          if (evt_cnt_q != {EVT_W{1'b1}}) evt_cnt_q <= evt_cnt_q + EVT_W'(1);
        end
        if (drop_start && (drop_cnt_q != {DROP_W{1'b1}})) begin
          drop_cnt_q <= drop_cnt_q + DROP_W'(1);
        end
      end
    end
  end

  assign tx_data_out  = data_q;
  assign tx_valid_out = valid_q;
  assign tx_eof_out   = eof_q;
  assign overrun_word = {sticky_q, afull_q, drop_cnt_q, evt_cnt_q};

endmodule

// File: tb/tb_gbe64_tx_overrun_monitor.sv
// Self-checking bench for gbe64_tx_overrun_monitor. Two instances share all inputs: one with a
// narrow event counter (reachable event saturation) and one with a narrow drop counter
// (reachable drop saturation). A frame-level reference model predicts every output each cycle.
module tb_gbe64_tx_overrun_monitor;

  localparam int DW      = 64;
  localparam int A_EVT_W = 10;
  localparam int B_EVT_W = 24;

  logic          user_clk = 1'b0;
  logic          user_rst_n;
  logic [DW-1:0] tx_data_in;
  logic          tx_valid_in, tx_eof_in, tx_afull, tx_overflow, clr;

  logic [DW-1:0] a_data, b_data;
  logic          a_valid, a_eof, b_valid, b_eof;
  logic [31:0]   a_word, b_word;

  always #5 user_clk = ~user_clk;

  gbe64_tx_overrun_monitor #(.DATA_W(DW), .EVT_W(A_EVT_W), .DROP_W(30 - A_EVT_W)) u_dut_a (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .tx_data_in   (tx_data_in),
    .tx_valid_in  (tx_valid_in),
    .tx_eof_in    (tx_eof_in),
    .tx_afull     (tx_afull),
    .tx_overflow  (tx_overflow),
    .clr          (clr),
    .tx_data_out  (a_data),
    .tx_valid_out (a_valid),
    .tx_eof_out   (a_eof),
    .overrun_word (a_word)
  );

  gbe64_tx_overrun_monitor #(.DATA_W(DW), .EVT_W(B_EVT_W), .DROP_W(30 - B_EVT_W)) u_dut_b (
    .user_clk     (user_clk),
    .user_rst_n   (user_rst_n),
    .tx_data_in   (tx_data_in),
    .tx_valid_in  (tx_valid_in),
    .tx_eof_in    (tx_eof_in),
    .tx_afull     (tx_afull),
    .tx_overflow  (tx_overflow),
    .clr          (clr),
    .tx_data_out  (b_data),
    .tx_valid_out (b_valid),
    .tx_eof_out   (b_eof),
    .overrun_word (b_word)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: frame membership, raw counts since last clear/reset.
  bit            m_in_frame, m_dropping, m_prev_ovf, m_sticky, m_afull;
  int unsigned   m_evt, m_drop;
  bit            e_valid, e_eof;
  logic [DW-1:0] e_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] pack(input int evt_w);
    int unsigned emax, dmax, e, d;
    logic [31:0] w;
    emax = (32'd1 << evt_w) - 1;
    dmax = (32'd1 << (30 - evt_w)) - 1;
    e = (m_evt > emax) ? emax : m_evt;
    d = (m_drop > dmax) ? dmax : m_drop;
    w = (32'(d) << evt_w) | 32'(e);
    w[31] = m_sticky;
    w[30] = m_afull;
    return w;
  endfunction

  task automatic step();
    bit fwd, start_drop, ovf_rise;
    @(posedge user_clk);
    #1;
    fwd = 1'b0;
    start_drop = 1'b0;
    if (!user_rst_n) begin
      m_in_frame = 0; m_dropping = 0; m_prev_ovf = 0; m_sticky = 0; m_afull = 0;
      m_evt = 0; m_drop = 0;
      e_valid = 0; e_eof = 0; e_data = '0;
    end else begin
      if (tx_valid_in) begin
        if (!m_in_frame) begin
          m_dropping = tx_afull | tx_overflow;
          start_drop = m_dropping;
          m_in_frame = 1;
        end
        fwd = !m_dropping;
        if (tx_eof_in) m_in_frame = 0;
      end
      e_valid = fwd;
      e_eof   = fwd & tx_eof_in;
      e_data  = tx_data_in;
      ovf_rise = tx_overflow & !m_prev_ovf;
      m_prev_ovf = tx_overflow;
      if (clr) begin
        m_evt = 0; m_drop = 0; m_sticky = 0;
      end else begin
        if (ovf_rise) begin
          m_evt++;
          m_sticky = 1;
        end
        if (start_drop) m_drop++;
      end
      m_afull = tx_afull;
    end
    check("valid", 64'(a_valid), 64'(e_valid));
    check("eof", 64'(a_eof), 64'(e_eof));
    if (e_valid || !user_rst_n) check("data", a_data, e_data);
    check("word_a", 64'(a_word), 64'(pack(A_EVT_W)));
    check("word_b", 64'(b_word), 64'(pack(B_EVT_W)));
  endtask

  task automatic drive(input bit v, input bit e, input bit af, input bit ov, input bit c,
                       input bit rn = 1'b1);
    user_rst_n  = rn;
    tx_valid_in = v;
    tx_eof_in   = e;
    tx_afull    = af;
    tx_overflow = ov;
    clr         = c;
    tx_data_in  = {$urandom, $urandom};
    step();
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 1, 1, 1, 0);
    check("rst_word", 64'(a_word), 64'd0);
    check("rst_valid", 64'(a_valid), 64'd0);

    // Clean 4-word frame.
    for (int i = 0; i < 4; i++) drive(1, i == 3, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    check("clean_word", 64'(a_word), 64'd0);

    // Drop at start, then a clean frame passes.
    drive(1, 0, 1, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);
    check("drop_cnt", 64'(a_word[29:A_EVT_W]), 64'd1);
    drive(1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0);

    // afull rising mid-frame; back-to-back with a following frame.
    for (int i = 0; i < 6; i++) drive(1, i == 5, i >= 2, 0, 0);
    drive(1, 1, 0, 0, 0);
    check("midafull_cnt", 64'(a_word[29:A_EVT_W]), 64'd1);

    // Overflow pulses: 1, 5 and 1 cycles long.
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0);
    check("evt_cnt", 64'(a_word[A_EVT_W-1:0]), 64'd3);
    check("sticky", 64'(a_word[31]), 64'd1);
    drive(0, 0, 0, 0, 1);
    check("clr_word", 64'({a_word[31], a_word[29:0]}), 64'd0);
    drive(0, 0, 0, 1, 1);
    drive(0, 0, 0, 0, 0);
    check("clr_edge", 64'(a_word[A_EVT_W-1:0]), 64'd0);

    // Reset mid-frame, then single-word frames.
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    check("rst_mid_valid", 64'(a_valid), 64'd0);
    drive(1, 1, 0, 0, 0);
    check("single_valid", 64'(a_valid), 64'd1);
    drive(1, 1, 1, 0, 0);
    check("single_drop", 64'(a_word[29:A_EVT_W]), 64'd1);

    // Overflow held through reset counts once.
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0);
    check("ovf_thru_rst", 64'(a_word[A_EVT_W-1:0]), 64'd1);

    // Saturation of both narrow counters.
    drive(0, 0, 0, 0, 1);
    for (int i = 0; i < (1 << A_EVT_W) + 4; i++) begin
      drive(0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 0);
    end
    check("evt_sat", 64'(a_word[A_EVT_W-1:0]), 64'((1 << A_EVT_W) - 1));
    for (int i = 0; i < (1 << (30 - B_EVT_W)) + 4; i++) drive(1, 1, 1, 0, 0);
    check("drop_sat", 64'(b_word[29:B_EVT_W]), 64'((1 << (30 - B_EVT_W)) - 1));

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(99) < 70, $urandom_range(99) < 25, $urandom_range(99) < 20,
            $urandom_range(99) < 10, $urandom_range(99) < 3, $urandom_range(199) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
